// File: rtl/cordic_vector_post.sv
// CORDIC vectoring output stage: removes the CORDIC gain with a bit-serial
// shift-add multiply and folds the pre-rotation quadrant back into the angle.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | ready for a new vector; angle correction done on accept
//   S_MUL  | one KCOMP bit per cycle, LSB first, counter 0..KFRAC
//   S_DONE | result held on the output until downstream accepts it
module cordic_vector_post #(
  parameter int N     = 31,
  parameter int M     = 31,
  parameter int KCOMP = 19898,
  parameter int KFRAC = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N:0]   x_in,
  input  logic        [M:0]   ang_in,
  input  logic        [1:0]   quad_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N:0]   mag_out,
  output logic        [M:0]   ang_out
);

  localparam int AW = N + KFRAC + 2;
  localparam int CW = (KFRAC > 0) ? $clog2(KFRAC + 1) : 1;
  localparam logic [KFRAC:0] K_VEC    = (KFRAC + 1)'(KCOMP);
  localparam logic [CW-1:0]  CNT_LAST = CW'(KFRAC);
  localparam logic [M:0]     QUARTER  = (M + 1)'(1) << (M - 1);
  localparam logic [M:0]     HALF     = (M + 1)'(1) << M;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic signed [N:0]     r_x;
  logic signed [AW-1:0]  r_acc;
  logic        [CW-1:0]  r_cnt;
  logic signed [N:0]     r_mag;
  logic        [M:0]     r_ang;

  logic signed [AW-1:0]  w_x_ext;
  logic signed [AW-1:0]  w_term;
  logic signed [AW-1:0]  w_acc_next;
  logic        [M:0]     w_off;
  logic                  w_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_MUL;
      S_MUL:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE) && !rst;
    out_valid = (r_state == S_DONE) && !rst;
  end

  // Partial products are full width; the only scaling is the final slice,
  // which is the arithmetic shift by KFRAC and gives floor semantics.
  assign w_x_ext    = {{(KFRAC + 1){r_x[N]}}, r_x};
  assign w_term     = K_VEC[r_cnt] ? (w_x_ext << r_cnt) : '0;
  assign w_acc_next = r_acc + w_term;
  assign w_last     = (r_cnt == CNT_LAST);

  always_comb begin
    w_off = '0;
    case (quad_in)
      2'b01:   w_off = QUARTER;
      2'b10:   w_off = (M + 1)'(0) - QUARTER;
      2'b11:   w_off = HALF;
      default: w_off = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_mag <= '0;
      r_ang <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x   <= x_in;
            r_acc <= '0;
            r_cnt <= '0;
            r_ang <= ang_in + w_off;
          end
        end
        S_MUL: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_mag <= w_acc_next[KFRAC +: N + 1];
        end
        default: ;
      endcase
    end
  end

  assign mag_out = r_mag;
  assign ang_out = r_ang;

endmodule
